button_conditioner: RTL and testbench

- Conditions the raw push-button and switch inputs for the display/calculator control FSM upstream of `top`.
  - Inputs conditioned: select, direction, mode.
- Per channel: 2-FF synchronizer, counter-based debounce, single-cycle press/release pulses, and hold-to-auto-repeat pulses.
- Lets the control FSM advance exactly one state per physical press, instead of one state per clock while the level is held.

---
 rtl/button_conditioner_pkg.sv | 17 +
 rtl/button_conditioner_if.sv | 29 ++
 rtl/button_channel.sv | 123 ++++++++++++
 rtl/button_conditioner.sv | 44 ++++
 tb/tb_button_conditioner.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing for the button conditioner.
// Defaults assume the 100 MHz system clock used by the display/calculator top.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } chan_state_e;

  localparam int unsigned ClkFreqHz         = 100_000_000;
  localparam int unsigned DefDebounceCycles = ClkFreqHz / 100;  // 10 ms
  localparam int unsigned DefHoldCycles     = ClkFreqHz / 2;    // 500 ms to first repeat
  localparam int unsigned DefRepeatCycles   = ClkFreqHz / 10;   // 100 ms between repeats

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw input pins and the control FSM.
// The conditioner is the slave: it consumes btn_raw and produces the conditioned view.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 4
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/button_channel.sv
// One button channel: 2-FF synchronizer, stable-count debounce FSM, edge pulses and
// hold-to-repeat. All outputs are registered.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  // Reload so the counter hits HoldLast again after REPEAT_CYCLES more cycles.
  localparam logic [HoldW-1:0] HoldReload =
      (REPEAT_CYCLES < HOLD_CYCLES) ? HoldW'(HOLD_CYCLES - REPEAT_CYCLES) : '0;

  logic             r_sync1;
  logic             r_sync2;
  chan_state_e      r_state;
  logic [DbW-1:0]   r_db_cnt;
  logic [HoldW-1:0] r_hold_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_repeat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= StIdle;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (r_sync2) begin
            r_state  <= StPressWait;
            r_db_cnt <= DbW'(1);
          end
        end

        StPressWait: begin
          if (!r_sync2) begin
            r_state  <= StIdle;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DbLast) begin
            r_state    <= StHeld;
            r_db_cnt   <= '0;
            r_level    <= 1'b1;
            r_press    <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DbW'(1);
          end
        end

        StHeld: begin
          if (!r_sync2) begin
            // Hold count stays frozen so a rejected release glitch resumes where it left off.
            r_state  <= StReleaseWait;
            r_db_cnt <= DbW'(1);
          end else if (REPEAT_EN) begin
            if (r_hold_cnt == HoldLast) begin
              r_repeat   <= 1'b1;
              r_hold_cnt <= HoldReload;
            end else begin
              r_hold_cnt <= r_hold_cnt + HoldW'(1);
            end
          end
        end

        StReleaseWait: begin
          if (r_sync2) begin
            r_state  <= StHeld;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DbLast) begin
            r_state    <= StIdle;
            r_db_cnt   <= '0;
            r_level    <= 1'b0;
            r_release  <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DbW'(1);
          end
        end

        default: begin
          r_state  <= StIdle;
          r_db_cnt <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw button/switch inputs so the control FSM sees one event per
// physical press, plus optional auto-repeat while a button is held.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_repeat;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (bus.btn_raw[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_repeat  (w_repeat[g])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.btn_repeat  = w_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: DEBOUNCE=4, HOLD=10, REPEAT=3, with a repeat-enabled and a
// repeat-disabled instance sharing clock and reset.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(4)) bus ();
  button_conditioner_if #(.N_BTN(4)) bus_nr ();

  button_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  button_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk (clk),
    .rst (rst),
    .bus (bus_nr.slave)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [3:0] rep);
    chk({tag, "_level"},   bus.btn_level,   lvl);
    chk({tag, "_press"},   bus.btn_press,   prs);
    chk({tag, "_release"}, bus.btn_release, rel);
    chk({tag, "_repeat"},  bus.btn_repeat,  rep);
  endtask

  initial begin
    logic [5:0] bounce_v;
    bounce_v = 6'b101101;  // bit i-1 is the raw value before edge i: 1,0,1,1,0,1

    // Reset with all raw inputs high
    rst = 1'b1;
    bus.btn_raw    = 4'hF;
    bus_nr.btn_raw = 4'h0;
    #2 rst = 1'b0;
    step();
    step();
    chk_all("in_reset", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("in_reset_nr_level", bus_nr.btn_level, 4'h0);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("rst_rel_k%0d", k), (k >= 6) ? 4'hF : 4'h0,
              (k == 6) ? 4'hF : 4'h0, 4'h0, 4'h0);
    end
    bus.btn_raw = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("rst_drop_k%0d", k), (k >= 6) ? 4'h0 : 4'hF, 4'h0,
              (k == 6) ? 4'hF : 4'h0, 4'h0);
    end

    // Clean press on channel 0, repeats 10,13,... cycles after the press pulse
    bus.btn_raw = 4'b0001;
    for (int j = 1; j <= 30; j++) begin
      step();
      chk_all($sformatf("clean_j%0d", j), (j >= 6) ? 4'b0001 : 4'b0000,
              (j == 6) ? 4'b0001 : 4'b0000, 4'b0000,
              (j >= 16 && (j - 16) % 3 == 0) ? 4'b0001 : 4'b0000);
    end
    bus.btn_raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("clean_rel_k%0d", k), (k >= 6) ? 4'b0000 : 4'b0001, 4'b0000,
              (k == 6) ? 4'b0001 : 4'b0000, (k == 1) ? 4'b0001 : 4'b0000);
    end

    // Bounce on channel 1: one press five edges after the last 0->1 edge-step
    for (int i = 1; i <= 14; i++) begin
      bus.btn_raw[1] = (i <= 6) ? bounce_v[i-1] : 1'b1;
      step();
      chk($sformatf("bounce_press_i%0d", i), bus.btn_press, (i == 11) ? 4'b0010 : 4'b0000);
      chk($sformatf("bounce_rel_i%0d", i), bus.btn_release, 4'b0000);
      chk($sformatf("bounce_lvl_i%0d", i), bus.btn_level, (i >= 11) ? 4'b0010 : 4'b0000);
    end
    bus.btn_raw[1] = 1'b0;
    repeat (10) step();
    chk("bounce_done_level", bus.btn_level, 4'b0000);

    // Release glitch on channel 2: 3 low cycles rejected, repeat delayed by the freeze
    for (int i = 1; i <= 22; i++) begin
      bus.btn_raw[2] = (i >= 9 && i <= 11) ? 1'b0 : 1'b1;
      step();
      chk_all($sformatf("glitch_i%0d", i), (i >= 6) ? 4'b0100 : 4'b0000,
              (i == 6) ? 4'b0100 : 4'b0000, 4'b0000, (i == 20) ? 4'b0100 : 4'b0000);
    end
    bus.btn_raw[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_all($sformatf("glitch_rel_k%0d", k), (k >= 6) ? 4'b0000 : 4'b0100, 4'b0000,
              (k == 6) ? 4'b0100 : 4'b0000, (k == 1) ? 4'b0100 : 4'b0000);
    end

    // Async reset while channel 3 is held
    bus.btn_raw[3] = 1'b1;
    repeat (8) step();
    chk("areset_pre_level", bus.btn_level, 4'b1000);
    #3 rst = 1'b0;
    #1;
    chk_all("areset_now", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step();
    step();
    chk_all("areset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("areset_rel_k%0d", k), (k >= 6) ? 4'b1000 : 4'b0000,
              (k == 6) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000);
    end

    // Repeat-disabled instance: long hold gives press/release but never repeat
    bus_nr.btn_raw = 4'b0001;
    for (int j = 1; j <= 40; j++) begin
      step();
      chk($sformatf("norep_press_j%0d", j), bus_nr.btn_press, (j == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("norep_repeat_j%0d", j), bus_nr.btn_repeat, 4'b0000);
      chk($sformatf("norep_lvl_j%0d", j), bus_nr.btn_level, (j >= 6) ? 4'b0001 : 4'b0000);
    end
    bus_nr.btn_raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("norep_rel_k%0d", k), bus_nr.btn_release, (k == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("norep_rrep_k%0d", k), bus_nr.btn_repeat, 4'b0000);
      chk($sformatf("norep_rlvl_k%0d", k), bus_nr.btn_level, (k >= 6) ? 4'b0000 : 4'b0001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
